// File: rtl/stl_rst_pkg.sv
// Shared definitions for the reset-release sequencer.
//   seq_state_e : sequencer states (SEQ_ERR only reachable with STL_RST_SEQ_TIMEOUT_EN)
//   cnt_width() : width of the shared delay counter for a given hold/gap/timeout set
//   DEF_*       : default parameter values
package stl_rst_pkg;

  localparam int unsigned DEF_N_STAGE  = 3;
  localparam int unsigned DEF_HOLD_CYC = 16;
  localparam int unsigned DEF_GAP_CYC  = 4;
  localparam int unsigned DEF_TO_CYC   = 256;

  typedef enum logic [2:0] {
    SEQ_HOLD,
    SEQ_WAIT_ACK,
    SEQ_GAP,
    SEQ_DONE,
    SEQ_ERR
  } seq_state_e;

  // Enough bits to hold the largest value ever loaded into the counter.
  function automatic int unsigned cnt_width(input int unsigned hold,
                                            input int unsigned gap,
                                            input int unsigned to);
    int unsigned m;
    m = hold;
    if (gap > m) m = gap;
    if (to > m) m = to;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/stl_rst_seq_if.sv
// Stage reset / acknowledge bundle of the reset-release sequencer.
//   soft_rst_req : restart request            (master -> slave)
//   stage_ack    : per-stage ready            (master -> slave)
//   stage_rst    : per-stage reset, active-high (slave -> master)
//   all_ready    : every stage released and acknowledged
//   busy         : sequence in progress
//   timeout_err  : sticky ack-timeout flag
//   err_stage    : stage that timed out
// The sequencer is the slave; the subsystem/controller side is the master.
interface stl_rst_seq_if
  import stl_rst_pkg::*;
#(
  parameter int unsigned N_STAGE = DEF_N_STAGE
);

  localparam int unsigned ERR_W = $clog2(N_STAGE) + 1;

  logic               soft_rst_req;
  logic [N_STAGE-1:0] stage_ack;
  logic [N_STAGE-1:0] stage_rst;
  logic               all_ready;
  logic               busy;
  logic               timeout_err;
  logic [ERR_W-1:0]   err_stage;

  modport master (
    output soft_rst_req, stage_ack,
    input  stage_rst, all_ready, busy, timeout_err, err_stage
  );

  modport slave (
    input  soft_rst_req, stage_ack,
    output stage_rst, all_ready, busy, timeout_err, err_stage
  );

endinterface

// File: rtl/stl_dly_cnt.sv
// Loadable down-counter shared by the hold, gap and timeout phases.
//   clk, rst  : clock, synchronous active-high reset (reloads RST_VAL)
//   load_i    : load value_i (wins over dec_i)
//   value_i   : value to load
//   dec_i     : decrement by one; saturates at zero
//   zero_o    : the current decrement brings the count to zero
module stl_dly_cnt #(
  parameter int unsigned W       = 8,
  parameter int unsigned RST_VAL = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= W'(RST_VAL);
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flags the edge on which the count lands on zero, so a phase loaded with
  // N ends exactly N edges later.
  assign zero_o = dec_i && (cnt_q == W'(1));

endmodule

// File: rtl/stl_rst_seq.sv
// Multi-stage reset-release sequencer.
// Releases stage resets one at a time in index order after a hold period;
// each stage must acknowledge before the next is released. A soft reset
// request re-runs the whole sequence.
//   clk, rst : clock, synchronous active-high reset
//   bus      : stl_rst_seq_if.slave (soft_rst_req, stage_ack in;
//              stage_rst, all_ready, busy, timeout_err, err_stage out)
// Optional feature macro: STL_RST_SEQ_TIMEOUT_EN (ack timeout + ERR state).
// Without it timeout_err and err_stage are tied low.
module stl_rst_seq
  import stl_rst_pkg::*;
#(
  parameter int unsigned N_STAGE  = DEF_N_STAGE,
  parameter int unsigned HOLD_CYC = DEF_HOLD_CYC,
  parameter int unsigned GAP_CYC  = DEF_GAP_CYC,
  parameter int unsigned TO_CYC   = DEF_TO_CYC
) (
  input  logic         clk,
  input  logic         rst,
  stl_rst_seq_if.slave bus
);

  localparam int unsigned CNT_W = cnt_width(HOLD_CYC, GAP_CYC, TO_CYC);
  localparam int unsigned IDX_W = (N_STAGE > 1) ? $clog2(N_STAGE) : 1;
  localparam int unsigned ERR_W = $clog2(N_STAGE) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STAGE - 1);

  seq_state_e         state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   idx_nxt;
  logic [N_STAGE-1:0] stage_rst_q;
  logic               all_ready_q;
  logic               busy_q;
`ifdef STL_RST_SEQ_TIMEOUT_EN
  logic               timeout_err_q;
  logic [ERR_W-1:0]   err_stage_q;
`endif

  logic               cnt_load;
  logic               cnt_dec;
  logic [CNT_W-1:0]   cnt_val;
  logic               cnt_zero;
  logic               ack_sel;

  assign ack_sel = bus.stage_ack[idx_q];
  assign idx_nxt = idx_q + 1'b1;

  // Counter control: every phase reloads the counter on entry, so there is
  // never a wrap to worry about.
  always_comb begin
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    cnt_val  = CNT_W'(HOLD_CYC);
    if (bus.soft_rst_req) begin
      cnt_load = 1'b1;
    end else begin
      case (state_q)
        SEQ_HOLD: begin
          cnt_dec = 1'b1;
`ifdef STL_RST_SEQ_TIMEOUT_EN
          if (cnt_zero) begin
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(TO_CYC);
          end
`endif
        end
        SEQ_WAIT_ACK: begin
          if (ack_sel) begin
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(GAP_CYC);
          end else begin
`ifdef STL_RST_SEQ_TIMEOUT_EN
            cnt_dec = 1'b1;
`endif
          end
        end
        SEQ_GAP: begin
          cnt_dec = 1'b1;
`ifdef STL_RST_SEQ_TIMEOUT_EN
          if (cnt_zero) begin
            cnt_load = 1'b1;
            cnt_val  = CNT_W'(TO_CYC);
          end
`endif
        end
        default: ;
      endcase
    end
  end

  stl_dly_cnt #(
    .W       (CNT_W),
    .RST_VAL (HOLD_CYC)
  ) u_dly_cnt (
    .clk     (clk),
    .rst     (rst),
    .load_i  (cnt_load),
    .value_i (cnt_val),
    .dec_i   (cnt_dec),
    .zero_o  (cnt_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= SEQ_HOLD;
      idx_q         <= '0;
      stage_rst_q   <= '1;
      all_ready_q   <= 1'b0;
      busy_q        <= 1'b1;
`ifdef STL_RST_SEQ_TIMEOUT_EN
      timeout_err_q <= 1'b0;
      err_stage_q   <= '0;
`endif
    end else if (bus.soft_rst_req) begin
      state_q       <= SEQ_HOLD;
      idx_q         <= '0;
      stage_rst_q   <= '1;
      all_ready_q   <= 1'b0;
      busy_q        <= 1'b1;
`ifdef STL_RST_SEQ_TIMEOUT_EN
      timeout_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        SEQ_HOLD: begin
          if (cnt_zero) begin
            stage_rst_q[0] <= 1'b0;
            idx_q          <= '0;
            state_q        <= SEQ_WAIT_ACK;
          end
        end
        SEQ_WAIT_ACK: begin
          if (ack_sel) begin
            if (idx_q == LAST_IDX) begin
              all_ready_q <= 1'b1;
              busy_q      <= 1'b0;
              state_q     <= SEQ_DONE;
            end else begin
              state_q     <= SEQ_GAP;
            end
          end
`ifdef STL_RST_SEQ_TIMEOUT_EN
          else if (cnt_zero) begin
            timeout_err_q <= 1'b1;
            err_stage_q   <= ERR_W'(idx_q);
            stage_rst_q   <= '1;
            busy_q        <= 1'b0;
            state_q       <= SEQ_ERR;
          end
`endif
        end
        SEQ_GAP: begin
          if (cnt_zero) begin
            idx_q                <= idx_nxt;
            stage_rst_q[idx_nxt] <= 1'b0;
            state_q              <= SEQ_WAIT_ACK;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stage_rst   = stage_rst_q;
  assign bus.all_ready   = all_ready_q;
  assign bus.busy        = busy_q;
`ifdef STL_RST_SEQ_TIMEOUT_EN
  assign bus.timeout_err = timeout_err_q;
  assign bus.err_stage   = err_stage_q;
`else
  assign bus.timeout_err = 1'b0;
  assign bus.err_stage   = '0;
`endif

endmodule

// File: tb/tb_stl_rst_seq.sv
// Bench for stl_rst_seq: directed timing scenarios plus randomized acks,
// soft resets and resets, compared each edge against a timestamp model.
module tb_stl_rst_seq;

  localparam int unsigned N    = 3;
  localparam int          HOLD = 16;
  localparam int          GAP  = 4;
  localparam int          TO   = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  // Reference model: count of released stages plus edge timestamps.
  int m_nrel, m_next_rel, m_wait_since, m_err_stage;
  bit m_wait, m_ready, m_err;

  stl_rst_seq_if #(.N_STAGE(N)) bus ();

  stl_rst_seq #(
    .N_STAGE  (N),
    .HOLD_CYC (HOLD),
    .GAP_CYC  (GAP),
    .TO_CYC   (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic s, input logic [N-1:0] a);
    if (r || s) begin
      m_nrel     = 0;
      m_next_rel = cyc + HOLD;
      m_wait     = 0;
      m_ready    = 0;
      m_err      = 0;
      if (r) m_err_stage = 0;
    end else if (m_err) begin
      // stuck until reset/soft reset
    end else if (m_nrel < N && !m_wait && cyc == m_next_rel) begin
      m_nrel++;
      m_wait       = 1;
      m_wait_since = cyc;
    end else if (m_wait) begin
      if (a[m_nrel-1]) begin
        m_wait = 0;
        if (m_nrel == N) m_ready = 1;
        else m_next_rel = cyc + GAP;
      end
`ifdef STL_RST_SEQ_TIMEOUT_EN
      else if (cyc == m_wait_since + TO) begin
        m_err       = 1;
        m_err_stage = m_nrel - 1;
        m_nrel      = 0;
        m_wait      = 0;
      end
`endif
    end
  endtask

  task automatic step(input logic r, input logic s, input logic [N-1:0] a);
    int exp_rst;
    @(negedge clk);
    rst              = r;
    bus.soft_rst_req = s;
    bus.stage_ack    = a;
    @(posedge clk);
    cyc++;
    model_edge(r, s, a);
    #1;
    exp_rst = ((1 << N) - 1) & ~((1 << m_nrel) - 1);
    check_eq("stage_rst", 32'(bus.stage_rst), 32'(exp_rst));
    check_eq("all_ready", 32'(bus.all_ready), 32'(m_ready));
    check_eq("busy", 32'(bus.busy), 32'(!m_ready && !m_err));
    check_eq("timeout_err", 32'(bus.timeout_err), 32'(m_err));
    check_eq("err_stage", 32'(bus.err_stage), 32'(m_err_stage));
  endtask

  initial begin
    logic [N-1:0] a;
    bus.soft_rst_req = 1'b0;
    bus.stage_ack    = '0;
    m_nrel = 0; m_next_rel = 0; m_wait_since = 0; m_err_stage = 0;
    m_wait = 0; m_ready = 0; m_err = 0;

    // Reset, acks held high (also during hold), soft restart at edge 30,
    // then stage 1 ack delayed to 10 edges after its release.
    repeat (5) step(1'b1, 1'b0, '1);
    check_eq("rst_stage_rst", 32'(bus.stage_rst), 32'h7);
    check_eq("rst_busy", 32'(bus.busy), 32'h1);
    check_eq("rst_all_ready", 32'(bus.all_ready), 32'h0);
    for (int e = 1; e <= 70; e++) begin
      a = (e >= 30 && e < 61) ? 3'b101 : 3'b111;
      step(1'b0, (e == 30), a);
      case (e)
        15: check_eq("e15_hold", 32'(bus.stage_rst), 32'h7);
        16: check_eq("e16_rel0", 32'(bus.stage_rst), 32'h6);
        20: check_eq("e20_gap", 32'(bus.stage_rst), 32'h6);
        21: check_eq("e21_rel1", 32'(bus.stage_rst), 32'h4);
        25: check_eq("e25_gap", 32'(bus.stage_rst), 32'h4);
        26: check_eq("e26_rel2", 32'(bus.stage_rst), 32'h0);
        27: begin
          check_eq("e27_ready", 32'(bus.all_ready), 32'h1);
          check_eq("e27_busy", 32'(bus.busy), 32'h0);
        end
        30: begin
          check_eq("e30_soft_rst", 32'(bus.stage_rst), 32'h7);
          check_eq("e30_soft_rdy", 32'(bus.all_ready), 32'h0);
        end
        45: check_eq("e45_hold", 32'(bus.stage_rst), 32'h7);
        46: check_eq("e46_rel0", 32'(bus.stage_rst), 32'h6);
        51: check_eq("e51_rel1", 32'(bus.stage_rst), 32'h4);
        64: check_eq("e64_wait", 32'(bus.stage_rst), 32'h4);
        65: check_eq("e65_rel2", 32'(bus.stage_rst), 32'h0);
        66: check_eq("e66_ready", 32'(bus.all_ready), 32'h1);
        default: ;
      endcase
    end

    // rst together with soft_rst_req in the middle of a gap.
    repeat (2) step(1'b1, 1'b0, '1);
    for (int e = 1; e <= 18; e++) step(1'b0, 1'b0, '1);
    step(1'b1, 1'b1, '1);
    check_eq("midgap_rst_sr", 32'(bus.stage_rst), 32'h7);
    check_eq("midgap_rst_busy", 32'(bus.busy), 32'h1);
    check_eq("midgap_rst_rdy", 32'(bus.all_ready), 32'h0);
    check_eq("midgap_rst_to", 32'(bus.timeout_err), 32'h0);
    check_eq("midgap_rst_es", 32'(bus.err_stage), 32'h0);

`ifdef STL_RST_SEQ_TIMEOUT_EN
    // Stage 1 never acks: released at edge 21, times out at 21+TO.
    for (int e = 1; e <= 55; e++) begin
      step(1'b0, 1'b0, 3'b101);
      if (e == 21 + TO - 1) check_eq("to_before", 32'(bus.timeout_err), 32'h0);
      if (e == 21 + TO) begin
        check_eq("to_err", 32'(bus.timeout_err), 32'h1);
        check_eq("to_stage", 32'(bus.err_stage), 32'h1);
        check_eq("to_rst", 32'(bus.stage_rst), 32'h7);
        check_eq("to_busy", 32'(bus.busy), 32'h0);
      end
    end
    step(1'b0, 1'b1, 3'b101);
    check_eq("to_soft_clear", 32'(bus.timeout_err), 32'h0);
`endif

    // Randomized acks, occasional soft resets and resets.
    for (int i = 0; i < 3000; i++) begin
      a = N'($urandom);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 149) == 0), a);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stl_rst_seq.md
# stl_rst_seq

Multi-stage reset-release sequencer. It sits directly behind the top-level reset synchronizer and drives the per-subsystem resets: IFU/cache, core pipeline, peripherals/difftest hooks. Stage resets are released one at a time, in index order, after a hold period. Each stage must acknowledge readiness before the next is released, and a soft-reset request re-runs the whole sequence without a global reset.

## Interface
Parameters:
- N_STAGE, 3: number of sequenced reset stages (1..8)
- HOLD_CYC, 16: edges with rst low before stage 0 is released (>=1)
- GAP_CYC, 4: edges between an ack being sampled and the next stage's release (>=1)
- TO_CYC, 256: ack timeout in edges (used only with the timeout feature, >=2)

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- soft_rst_req  in  1  restart the sequence; sampled every edge
- stage_ack  in  N_STAGE  stage i reports ready after its reset is released
- stage_rst  out  N_STAGE  per-stage reset, active-high, registered
- all_ready  out  1  every stage released and acknowledged
- busy  out  1  sequence in progress
- timeout_err  out  1  an ack timed out (sticky)
- err_stage  out  $clog2(N_STAGE)+1  index of the stage that timed out

## Operation
- Reset values: stage_rst all ones, all_ready 0, busy 1, timeout_err 0, err_stage 0, state HOLD, counter = HOLD_CYC.
- States: HOLD, WAIT_ACK, GAP, DONE, ERR. ERR exists only with the timeout feature.
- HOLD: counter decrements each edge. On the edge it reaches zero, stage_rst[0] is cleared and the state moves to WAIT_ACK with idx=0.
- WAIT_ACK: only stage_ack[idx] is examined.
  - Ack sampled high with idx<N_STAGE-1: go to GAP and load counter = GAP_CYC.
  - Ack sampled high with idx=N_STAGE-1: go to DONE, set all_ready=1, set busy=0.
- GAP: counter decrements. At zero, idx increments, stage_rst[idx] is cleared, and the state returns to WAIT_ACK.
- Released stages stay released; the sequence never re-asserts a single stage.
- Acks from stages not yet released, and ack drops after release or in DONE, are ignored.
- soft_rst_req sampled high in any state: all stage_rst set, all_ready 0, busy 1, timeout_err 0, idx 0, state HOLD, counter reloaded with HOLD_CYC.
- rst has priority over soft_rst_req.
- Counter width: $clog2(max(HOLD_CYC,GAP_CYC,TO_CYC)+1). There is no wrap-around; the counter is always reloaded before use.

## Timing
- Edge 1 is the first rising edge with rst sampled low.
- stage_rst[0] falls at edge HOLD_CYC.
- An ack is sampled at the earliest one edge after its stage's release. An ack already high at release is consumed at release+1.
- stage_rst[i+1] falls GAP_CYC edges after the edge that sampled stage_ack[i].
- all_ready rises on the edge that samples the last ack.
- With every ack held high, all_ready rises at edge HOLD_CYC + (N_STAGE-1)*(GAP_CYC+1) + 1.
- A soft_rst_req sampled at edge k gives stage_rst all ones at edge k. The new stage 0 release happens at k+HOLD_CYC.
- Outputs change only on clock edges; there are no combinational input-to-output paths.

## Configuration
- Macro: STL_RST_SEQ_TIMEOUT_EN.
- Defined:
  - Entering WAIT_ACK loads counter = TO_CYC.
  - If the counter reaches zero with no ack sampled, set timeout_err=1, err_stage=idx, all stage_rst re-asserted, busy=0, state ERR.
  - ERR holds until rst or soft_rst_req.
- Undefined:
  - WAIT_ACK waits indefinitely.
  - timeout_err and err_stage are tied to 0; the ports remain present.

## Structure
- Shared package stl_rst_pkg holds:
  - the state enum (SEQ_HOLD, SEQ_WAIT_ACK, SEQ_GAP, SEQ_DONE, SEQ_ERR)
  - the counter-width helper function
  - default parameter constants
- One sub-module, stl_dly_cnt: a loadable down-counter with load, value, and a zero flag. It is shared by the hold, gap and timeout phases.

## Test plan
Parameters for all scenarios: N_STAGE=3, HOLD_CYC=16, GAP_CYC=4, TO_CYC=32.
1. rst high for 5 cycles, then low, acks tied high:
   - stage_rst=111 and busy=1 through edge 15
   - stage_rst[0]=0 at edge 16, [1]=0 at edge 21, [2]=0 at edge 26
   - all_ready=1 and busy=0 at edge 27
2. stage_ack[1] delayed until 10 edges after its release: stage_rst[2] falls exactly 4 edges after that ack is sampled, and never earlier.
3. stage_ack=111 asserted during HOLD: no release before edge 16, and acks for unreleased stages have no effect.
4. soft_rst_req pulsed one cycle at edge 30 after DONE:
   - stage_rst=111 and all_ready=0 at edge 30
   - stage_rst[0]=0 at edge 46
5. With STL_RST_SEQ_TIMEOUT_EN, stage_ack[1] held 0:
   - timeout_err=1, err_stage=1, stage_rst=111, busy=0 at 32 edges after entering WAIT_ACK for stage 1
   - a following soft_rst_req clears timeout_err
6. rst asserted mid-GAP together with soft_rst_req: all outputs return to their reset values on that edge.
